multicycle_ctrl_g7: RTL
=======================

MULTICYCLE_CTRL_G7 -- requirements
Module: multicycle_ctrl_g7

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: op  input  7  opcode of the instruction register.
REQ-004 SHALL have port: zero  input  1  ALU zero flag from the current ALU result.
REQ-005 SHALL have port: mem_ready  input  1  memory completes the current access this cycle.
REQ-006 SHALL have ports (output, 1 bit): mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, instr_retired.
REQ-007 SHALL have ports (output, 2 bits): ALUSrcA (00 PC, 01 OldPC, 10 RD1), ALUSrcB (00 RD2, 01 ImmExt, 10 const 4), ResultSrc (00 ALUOut, 01 Data, 10 ALUResult), ALUOp (00 add, 01 sub, 10 funct-decoded).
REQ-008 SHALL have port: state_dbg  output  4  current state encoding.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
REQ-010 SHALL decode opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111; all others are illegal.
REQ-011 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; stay while mem_ready=0; when mem_ready=1, assert IRWrite=1 and PCWrite=1 for that cycle and go to DECODE.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target); next: lw/sw->MEMADR, R->EXECR, I->EXECI, beq->BEQ, jal->JAL, illegal->per REQ-025.
REQ-013 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; lw->MEMREAD, sw->MEMWRITE.
REQ-014 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then MEMWB.
REQ-015 MEMWB: ResultSrc=01, RegWrite=1; ->FETCH.
REQ-016 MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle held; hold until mem_ready=1, then FETCH.
REQ-017 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both ->ALUWB.
REQ-018 ALUWB: ResultSrc=00, RegWrite=1; ->FETCH.
REQ-019 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=zero; ->FETCH.
REQ-020 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; ->ALUWB.
REQ-021 Outputs not listed for a state SHALL be 0 (selects 00); PCWrite/IRWrite are the only outputs depending on inputs (mem_ready, zero).
REQ-022 instr_retired SHALL pulse 1 for one cycle on exit from MEMWB, MEMWRITE (mem_ready=1), ALUWB and BEQ.
REQ-023 Latency (mem_ready always 1): R/I/jal 4 cycles, lw 5, sw 4, beq 3.
REQ-024 mem_ready outside FETCH/MEMREAD/MEMWRITE SHALL be ignored.

Reset
REQ-025 reset=1 SHALL force state FETCH immediately; while asserted mem_req, MemWrite, IRWrite, PCWrite, RegWrite, instr_retired SHALL be 0 and selects SHALL hold FETCH values.
REQ-026 Reset mid-access (MEMREAD/MEMWRITE) SHALL abandon the access; first cycle after release SHALL be FETCH with mem_req=1.

Configuration
REQ-027 With G7_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE ->TRAP; TRAP holds all enables 0, state_dbg=11, exits only by reset.
REQ-028 Without G7_ILLEGAL_TRAP_EN: illegal opcode in DECODE ->FETCH (NOP, no instr_retired); TRAP unreachable.

Verification
REQ-029 reset pulse mid-MEMREAD -> state_dbg=0, MemWrite=0, RegWrite=0; next cycle mem_req=1.
REQ-030 op=0110011, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8; ALUOp=10 in state 6.
REQ-031 op=0000011, mem_ready low 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with ResultSrc=01, RegWrite=1.
REQ-032 op=1100011, zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; ALUOp=01 both.
REQ-033 op=0000000 -> with G7_ILLEGAL_TRAP_EN state_dbg=11 stuck until reset; without, state 0 after DECODE, instr_retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_g7.sv
// multicycle_ctrl_g7 -- Moore control FSM for a multicycle RV32-style datapath.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset (forces FETCH immediately)
//   op[6:0]        opcode field of the instruction register
//   zero           ALU zero flag (only used by BEQ for PCWrite)
//   mem_ready      memory completes the current access this cycle
//   mem_req        memory access request
//   MemWrite       memory write strobe
//   IRWrite        instruction register load
//   PCWrite        program counter load
//   RegWrite       register file write
//   AdrSrc         memory address select (0 PC, 1 ALUOut)
//   instr_retired  one-cycle pulse, registered, after an instruction completes
//   ALUSrcA[1:0]   00 PC, 01 OldPC, 10 RD1
//   ALUSrcB[1:0]   00 RD2, 01 ImmExt, 10 const 4
//   ResultSrc[1:0] 00 ALUOut, 01 Data, 10 ALUResult
//   ALUOp[1:0]     00 add, 01 sub, 10 funct-decoded
//   state_dbg[3:0] current state encoding
//
// Build option: define G7_ILLEGAL_TRAP_EN to send illegal opcodes to a TRAP
// state that only reset leaves; otherwise illegal opcodes execute as a NOP.

module multicycle_ctrl_g7 (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       instr_retired,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state, state_nxt;
  logic   retired_q, retired_nxt;

  // Raw (ungated) enables; reset masks them below so nothing leaks out
  // while reset is held, even though the state is already FETCH.
  logic   mem_req_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      retired_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      retired_q <= retired_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_req_c   = 1'b0;
    memwrite_c  = 1'b0;
    irwrite_c   = 1'b0;
    pcwrite_c   = 1'b0;
    regwrite_c  = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUOp       = 2'b00;
    retired_nxt = 1'b0;

    unique case (state)
      FETCH: begin
        mem_req_c = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECR;
          OP_I:         state_nxt = EXECI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
`ifdef G7_ILLEGAL_TRAP_EN
          default:      state_nxt = TRAP;
`else
          default:      state_nxt = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regwrite_c  = 1'b1;
        retired_nxt = 1'b1;
        state_nxt   = FETCH;
      end
      MEMWRITE: begin
        mem_req_c  = 1'b1;
        AdrSrc     = 1'b1;
        memwrite_c = 1'b1;
        if (mem_ready) begin
          retired_nxt = 1'b1;
          state_nxt   = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b10;
        state_nxt = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        regwrite_c  = 1'b1;
        retired_nxt = 1'b1;
        state_nxt   = FETCH;
      end
      BEQ: begin
        ALUSrcA     = 2'b10;
        ALUOp       = 2'b01;
        pcwrite_c   = zero;
        retired_nxt = 1'b1;
        state_nxt   = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcwrite_c = 1'b1;
        state_nxt = ALUWB;
      end
      TRAP: begin
`ifdef G7_ILLEGAL_TRAP_EN
        state_nxt = TRAP;
`else
        state_nxt = FETCH;
`endif
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign mem_req       = mem_req_c  & ~reset;
  assign MemWrite      = memwrite_c & ~reset;
  assign IRWrite       = irwrite_c  & ~reset;
  assign PCWrite       = pcwrite_c  & ~reset;
  assign RegWrite      = regwrite_c & ~reset;
  assign instr_retired = retired_q;
  assign state_dbg     = state;

endmodule
